// File: rtl/delay_share_sched_pkg.sv
// Shared types and helpers for the delay-share scheduler and its arbiter.
package delay_share_sched_pkg;

    localparam int DLY_MIN = 1;

    // Default-configuration queue entry; the top builds the same layout from its own parameters.
    typedef struct packed {
        logic [7:0] data;
        logic [0:0] id;
        logic [7:0] due;
    } entry_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/delay_share_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the pointer, pointer advances past each grant.
module rr_arbiter
    import delay_share_sched_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N-1:0]          i_req,
    input  logic                  i_en,
    output logic [N-1:0]          o_gnt,
    output logic [clog2(N)-1:0]   o_idx,
    output logic                  o_any
);

    localparam int PW = clog2(N);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = PW'((int'(r_ptr) + k) % N);
            if (i_en && !o_any && i_req[w_cand]) begin
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
                o_any         = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (o_any) begin
            r_ptr <= (o_idx == PW'(N - 1)) ? '0 : o_idx + 1'b1;
        end
    end

endmodule

// File: rtl/delay_share_sched.sv
// Shares one programmable fixed-latency delay among NREQ requesters via a
// round-robin grant and a timestamped circular pending queue.
module delay_share_sched
    import delay_share_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    parameter int DEPTH = 16,
    parameter int CW    = 8
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic [NREQ-1:0]          REQ_I,
    input  logic [NREQ*WIDTH-1:0]    DATA_I,
    output logic [NREQ-1:0]          GNT_O,
    input  logic [CW-1:0]            DLY_I,
    output logic [CW-1:0]            DLY_ACT_O,
    output logic                     OUT_VALID_O,
    output logic [WIDTH-1:0]         OUT_DATA_O,
    output logic [clog2(NREQ)-1:0]   OUT_ID_O,
    output logic                     FULL_O,
    output logic                     EMPTY_O
);

    localparam int IDW = clog2(NREQ);
    localparam int AW  = clog2(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [IDW-1:0]   id;
        logic [CW-1:0]    due;
    } q_entry_t;

    q_entry_t         r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;
    logic [CW-1:0]    r_timer;
    logic [CW-1:0]    r_dly;

    q_entry_t         w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_en;
    logic             w_any;
    logic [NREQ-1:0]  w_gnt;
    logic [IDW-1:0]   w_idx;
    logic [WIDTH-1:0] w_push_data;

    function automatic logic [CW-1:0] dly_clamp(input logic [CW-1:0] d);
        return (d == '0) ? CW'(DLY_MIN) : d;
    endfunction

    assign w_full  = (r_cnt == (AW+1)'(DEPTH));
    assign w_empty = (r_cnt == '0);
    assign w_head  = r_mem[r_rp];
    assign w_pop   = !w_empty && (r_timer == w_head.due);
    // A full queue may still accept when its head leaves on the same edge.
    assign w_en    = !RST_I && (!w_full || w_pop);

    rr_arbiter #(.N(NREQ)) u_arb (
        .i_clk (CLK_I),
        .i_rst (RST_I),
        .i_req (REQ_I),
        .i_en  (w_en),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_comb begin
        w_push_data = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (w_idx == IDW'(r)) w_push_data = DATA_I[r*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge CLK_I) begin
        if (w_any) begin
            r_mem[r_wp] <= '{data: w_push_data, id: w_idx, due: r_timer + r_dly};
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_cnt       <= '0;
            r_timer     <= '0;
            r_dly       <= dly_clamp(DLY_I);
            OUT_VALID_O <= 1'b0;
            OUT_DATA_O  <= '0;
            OUT_ID_O    <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
            if (w_any) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            case ({w_any, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            // Delay changes only land while nothing is in flight, so queued dues stay ordered.
            if (w_empty && !w_any) r_dly <= dly_clamp(DLY_I);
            OUT_VALID_O <= w_pop;
            if (w_pop) begin
                OUT_DATA_O <= w_head.data;
                OUT_ID_O   <= w_head.id;
            end
        end
    end

    assign GNT_O     = w_gnt;
    assign DLY_ACT_O = r_dly;
    assign FULL_O    = w_full;
    assign EMPTY_O   = w_empty;

endmodule

// File: tb/tb_delay_share_sched.sv
// Directed bench for delay_share_sched with DEPTH=4 and hand-computed expectations.
module tb_delay_share_sched;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] data;
    logic [1:0]  gnt;
    logic [7:0]  dly;
    logic [7:0]  dly_act;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [0:0]  out_id;
    logic        full;
    logic        empty;

    int checks = 0;
    int errors = 0;

    delay_share_sched #(.WIDTH(8), .NREQ(2), .DEPTH(4), .CW(8)) dut (
        .CLK_I       (clk),
        .RST_I       (rst),
        .REQ_I       (req),
        .DATA_I      (data),
        .GNT_O       (gnt),
        .DLY_I       (dly),
        .DLY_ACT_O   (dly_act),
        .OUT_VALID_O (out_valid),
        .OUT_DATA_O  (out_data),
        .OUT_ID_O    (out_id),
        .FULL_O      (full),
        .EMPTY_O     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] d);
        rst  = 1'b1;
        req  = 2'b00;
        data = 16'h0000;
        dly  = d;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int acc;
        int seen;
        logic granted;

        // Test 1: single event, delay 3, plus reset state
        do_reset(8'd3);
        chk("t1_rst_valid", 32'(out_valid), 32'd0);
        chk("t1_rst_data", 32'(out_data), 32'd0);
        chk("t1_rst_id", 32'(out_id), 32'd0);
        chk("t1_rst_empty", 32'(empty), 32'd1);
        chk("t1_rst_full", 32'(full), 32'd0);
        chk("t1_rst_dly", 32'(dly_act), 32'd3);
        req  = 2'b01;
        data = 16'h00A5;
        #1 chk("t1_gnt", 32'(gnt), 32'h1);
        tick();
        req = 2'b00;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("t1_valid", 32'(out_valid), (i == 3) ? 32'd1 : 32'd0);
            if (i >= 3) begin
                chk("t1_data", 32'(out_data), 32'hA5);
                chk("t1_id", 32'(out_id), 32'd0);
            end
        end

        // Test 2: both requesters, delay 2, alternating grants
        do_reset(8'd2);
        data = 16'h2211;
        req  = 2'b11;
        for (int i = 0; i < 7; i++) begin
            if (i == 4) req = 2'b00;
            if (i < 4) #1 chk("t2_gnt", 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            chk("t2_valid", 32'(out_valid), (i >= 2 && i <= 5) ? 32'd1 : 32'd0);
            if (i >= 2 && i <= 5) begin
                chk("t2_id", 32'(out_id), 32'((i - 2) % 2));
                chk("t2_data", 32'(out_data), ((i - 2) % 2 == 0) ? 32'h11 : 32'h22);
            end
        end

        // Test 3: DEPTH=4 fills with delay 10, resumes on the first pop
        do_reset(8'd10);
        acc = 0;
        req = 2'b01;
        for (int n = 0; n < 14; n++) begin
            data = 16'(8'h30 + acc);
            #1;
            chk("t3_gnt", 32'(gnt), (n < 4 || n >= 10) ? 32'h1 : 32'h0);
            chk("t3_full", 32'(full), (n >= 4) ? 32'd1 : 32'd0);
            granted = gnt[0];
            tick();
            if (granted) acc++;
            chk("t3_valid", 32'(out_valid), (n >= 10) ? 32'd1 : 32'd0);
            if (n >= 10) chk("t3_data", 32'(out_data), 32'(8'h30 + (n - 10)));
        end
        req = 2'b00;

        // Test 4: accept at timer 250, due wraps to 4
        do_reset(8'd10);
        repeat (250) tick();
        req  = 2'b01;
        data = 16'h004C;
        #1 chk("t4_gnt", 32'(gnt), 32'h1);
        tick();
        req = 2'b00;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("t4_valid", 32'(out_valid), (i == 10) ? 32'd1 : 32'd0);
        end
        chk("t4_data", 32'(out_data), 32'h4C);

        // Test 5: delay change deferred until queue drains; 0 acts as 1
        do_reset(8'd2);
        req  = 2'b01;
        data = 16'h0051;
        #1 chk("t5_gnt0", 32'(gnt), 32'h1);
        tick();
        data = 16'h0052;
        dly  = 8'd5;
        #1 chk("t5_gnt1", 32'(gnt), 32'h1);
        tick();
        req = 2'b00;
        chk("t5_dly_e1", 32'(dly_act), 32'd2);
        tick();
        chk("t5_valid_e2", 32'(out_valid), 32'd1);
        chk("t5_data_e2", 32'(out_data), 32'h51);
        chk("t5_dly_e2", 32'(dly_act), 32'd2);
        tick();
        chk("t5_valid_e3", 32'(out_valid), 32'd1);
        chk("t5_data_e3", 32'(out_data), 32'h52);
        chk("t5_dly_e3", 32'(dly_act), 32'd2);
        tick();
        chk("t5_dly_e4", 32'(dly_act), 32'd5);
        chk("t5_valid_e4", 32'(out_valid), 32'd0);
        req  = 2'b01;
        data = 16'h0053;
        #1 chk("t5_gnt5", 32'(gnt), 32'h1);
        tick();
        req = 2'b00;
        for (int i = 6; i <= 10; i++) begin
            tick();
            chk("t5_valid_d5", 32'(out_valid), (i == 10) ? 32'd1 : 32'd0);
        end
        chk("t5_data_d5", 32'(out_data), 32'h53);
        dly = 8'd0;
        tick();
        chk("t5_dly_zero", 32'(dly_act), 32'd1);
        req  = 2'b01;
        data = 16'h0054;
        tick();
        req = 2'b00;
        chk("t5_valid_e12", 32'(out_valid), 32'd0);
        tick();
        chk("t5_valid_e13", 32'(out_valid), 32'd1);
        chk("t5_data_e13", 32'(out_data), 32'h54);

        // Test 6: reset with three events pending
        do_reset(8'd4);
        req = 2'b01;
        for (int n = 0; n < 4; n++) begin
            data = 16'(8'h61 + n);
            tick();
        end
        req = 2'b00;
        tick();
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        chk("t6_pre_data", 32'(out_data), 32'h61);
        chk("t6_pre_empty", 32'(empty), 32'd0);
        rst = 1'b1;
        req = 2'b01;
        #1 chk("t6_rst_gnt", 32'(gnt), 32'h0);
        tick();
        req = 2'b00;
        rst = 1'b0;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_data", 32'(out_data), 32'd0);
        chk("t6_id", 32'(out_id), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_full", 32'(full), 32'd0);
        seen = 0;
        repeat (12) begin
            tick();
            if (out_valid) seen++;
        end
        chk("t6_no_emit", 32'(seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
